// File: rtl/seq_logic_slicer.sv
// Time-multiplexed bitwise logic unit: AND/OR/XOR/NOR of two WIDTH-bit operands,
// one SLICE-bit slice per clock from the LSB, with start/busy/done handshake and zero flag.
module seq_logic_slicer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("seq_logic_slicer: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_val;
    logic [WIDTH-1:0] result_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Slice selection as a constant-index mux keeps every part-select statically sized.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
                slice_a = a_q[i*SLICE +: SLICE];
                slice_b = b_q[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        slice_val = '0;
        case (op_q)
            2'b00:   slice_val = slice_a & slice_b;
            2'b01:   slice_val = slice_a | slice_b;
            2'b10:   slice_val = slice_a ^ slice_b;
            default: slice_val = ~(slice_a | slice_b);
        endcase
    end

    always_comb begin
        result_next = result;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
                result_next[i*SLICE +: SLICE] = slice_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            idx    <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        idx    <= '0;
                        result <= '0;
                        zero   <= 1'b0;
                    end
                end
                RUN: begin
                    result <= result_next;
                    // zero must see the final slice, so it is taken from the next-result value.
                    if (idx == LAST) begin
                        zero <= (result_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_logic_slicer.sv
// Scoreboard bench for seq_logic_slicer: drivers push expected results, per-DUT
// monitors pop and compare on each done pulse; three width/slice configurations.
module tb_seq_logic_slicer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t q64[$];
    int   ndone32 = 0;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0, result32;
    logic        busy32, done32, zero32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, result8;
    logic        busy8, done8, zero8;

    logic        start64 = 1'b0;
    logic [1:0]  op64 = '0;
    logic [63:0] a64 = '0, b64 = '0, result64;
    logic        busy64, done64, zero64;

    seq_logic_slicer u32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32), .zero(zero32)
    );

    seq_logic_slicer #(.WIDTH(8), .SLICE(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .zero(zero8)
    );

    seq_logic_slicer #(.WIDTH(64), .SLICE(16)) u64 (
        .clk(clk), .reset(reset), .start(start64), .op(op64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .result(result64), .zero(zero64)
    );

    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic [1:0] o, input int w);
        logic [63:0] r;
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (o)
            2'd0:    r = x & y;
            2'd1:    r = x | y;
            2'd2:    r = x ^ y;
            default: r = ~(x | y);
        endcase
        return r & m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] r, input int c);
        exp_t e;
        e.res = r;
        e.z   = (r == 64'd0);
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (busy32 || done32) check("busy_done_excl32", busy32 & done32, 0);
            if (done32) begin
                ndone32++;
                if (q32.size() == 0) check("unexpected_done32", 1, 0);
                else begin
                    e = q32.pop_front();
                    check("result32", result32, e.res);
                    check("zero32", zero32, e.z);
                    check("latency32", cyc, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done8) begin
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                e = q8.pop_front();
                check("result8", result8, e.res);
                check("zero8", zero8, e.z);
                check("latency8", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done64) begin
            if (q64.size() == 0) check("unexpected_done64", 1, 0);
            else begin
                e = q64.pop_front();
                check("result64", result64, e.res);
                check("zero64", zero64, e.z);
                check("latency64", cyc, e.cyc);
            end
        end
    end

    task automatic issue32(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
        @(negedge clk);
        a32 = x; b32 = y; op32 = o; start32 = 1'b1;
        @(posedge clk); #1;
        q32.push_back(mk(model(x, y, o, 32), cyc + 8));
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        @(negedge clk);
        a8 = x; b8 = y; op8 = o; start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back(mk(model(x, y, o, 8), cyc + 1));
        start8 = 1'b0;
    endtask

    task automatic issue64(input logic [63:0] x, input logic [63:0] y, input logic [1:0] o);
        @(negedge clk);
        a64 = x; b64 = y; op64 = o; start64 = 1'b1;
        @(posedge clk); #1;
        q64.push_back(mk(model(x, y, o, 64), cyc + 4));
        start64 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q32.size() == 0 && q8.size() == 0 && q64.size() == 0) break;
            @(negedge clk); #1;
        end
        check("drain_timeout", q32.size() + q8.size() + q64.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          n0;
        logic [31:0] x, y;
        logic [1:0]  o;

        repeat (3) @(negedge clk);
        check("reset_busy", busy32, 0);
        check("reset_done", done32, 0);
        check("reset_result", result32, 0);
        check("reset_zero", zero32, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", busy32, 0);
            check("idle_done", done32, 0);
            check("idle_result", result32, 0);
        end

        // AND with partial-result observation after three slice edges
        issue32(32'hF0F0_1234, 32'hFF00_FF0F, 2'b00);
        repeat (3) @(posedge clk);
        #1 check("partial_and", result32, 32'h0000_0204);
        check("partial_busy", busy32, 1);
        drain();

        for (int m = 0; m < 4; m++) begin
            issue32(32'hAAAA_AAAA, 32'h5555_5555, 2'(m));
            drain();
        end

        // operand isolation: change inputs and pulse start mid-run
        n0 = ndone32;
        issue32(32'h1234_5678, 32'h0F0F_F0F0, 2'b10);
        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; op32 = 2'b11; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("single_done", ndone32 - n0, 1);

        // back-to-back: start held through the done cycle
        @(negedge clk);
        a32 = 32'hDEAD_BEEF; b32 = 32'h0F0F_0F0F; op32 = 2'b01; start32 = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        q32.push_back(mk(model(32'hDEAD_BEEF, 32'h0F0F_0F0F, 2'b01, 32), acc + 8));
        a32 = 32'h1357_9BDF; b32 = 32'hFFFF_0000; op32 = 2'b10;
        repeat (9) @(posedge clk);
        #1 start32 = 1'b0;
        q32.push_back(mk(model(32'h1357_9BDF, 32'hFFFF_0000, 2'b10, 32), acc + 17));
        drain();

        // asynchronous reset mid-run (after slice 4 written) aborts the operation
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        q32.delete();
        #1;
        check("abort_busy", busy32, 0);
        check("abort_done", done32, 0);
        check("abort_result", result32, 0);
        check("abort_zero", zero32, 0);
        n0 = ndone32;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done", ndone32 - n0, 0);
        check("abort_result_after", result32, 0);

        for (int i = 0; i < 20; i++) begin
            x = $urandom; y = $urandom; o = 2'($urandom_range(0, 3));
            if (i % 5 == 0) y = x;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue32(x, y, o);
            drain();
        end

        for (int i = 0; i < 10; i++) begin
            issue8(8'($urandom), 8'($urandom), 2'b10);
            drain();
            issue64({$urandom, $urandom}, {$urandom, $urandom}, 2'b10);
            drain();
        end
        issue8(8'h5A, 8'h5A, 2'b10);
        drain();
        issue64(64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 2'b11);
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
